// File: rtl/boolean_unit_if.sv
// boolean_unit_if: function inputs, table load and monitor outputs of boolean_unit
interface boolean_unit_if #(
   parameter int CNT_W = 16
);
   logic             A;
   logic             B;
   logic             C;
   logic             F;
   logic             f_q;
   logic             f_rise;
   logic [CNT_W-1:0] hi_cnt;
   logic             cnt_clr;
   logic             tt_load;
   logic [7:0]       tt_data;
   modport master (
      output A, B, C, cnt_clr, tt_load, tt_data,
      input  F, f_q, f_rise, hi_cnt
   );
   modport slave (
      input  A, B, C, cnt_clr, tt_load, tt_data,
      output F, f_q, f_rise, hi_cnt
   );
endinterface

// File: rtl/boolean_unit.sv
// boolean_unit: 3-input truth-table function with registered copy, rise pulse and saturating high counter; BOOLEAN_PROG_EN adds a loadable table
module boolean_unit #(
   parameter logic [7:0] TT_INIT = 8'hAC,
   parameter int         CNT_W   = 16
) (
   input logic           clk,
   input logic           rst_n,
   boolean_unit_if.slave bus
);
   logic [7:0]       tt;
   logic             f;
   logic             f_q;
   logic             f_rise;
   logic [CNT_W-1:0] hi_cnt;
`ifdef BOOLEAN_PROG_EN
   // loadable table; a load becomes visible to F only after the edge, so f_q samples the old function
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tt <= TT_INIT;
      else if (bus.tt_load) tt <= bus.tt_data;
   end
`else
   assign tt = TT_INIT;
`endif
   assign f = tt[{bus.A, bus.B, bus.C}];
   // monitor state: registered F, its rising edge, and a clear-priority saturating count of high samples
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_q    <= 1'b0;
         f_rise <= 1'b0;
         hi_cnt <= '0;
      end else begin
         f_q    <= f;
         f_rise <= f & ~f_q;
         if (bus.cnt_clr) hi_cnt <= '0;
         else if (f && hi_cnt != '1) hi_cnt <= hi_cnt + CNT_W'(1);
      end
   end
   assign bus.F      = f;
   assign bus.f_q    = f_q;
   assign bus.f_rise = f_rise;
   assign bus.hi_cnt = hi_cnt;
endmodule

// File: tb/tb_boolean_unit.sv
// tb_boolean_unit: directed checks of boolean_unit (16-bit counter instance plus a 4-bit saturation instance)
module tb_boolean_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   boolean_unit_if #(.CNT_W(16)) b ();
   boolean_unit_if #(.CNT_W(4))  s ();
   boolean_unit #(.CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(b.slave));
   boolean_unit #(.CNT_W(4))  dut_s (.clk(clk), .rst_n(rst_n), .bus(s.slave));
   assign s.A       = b.A;
   assign s.B       = b.B;
   assign s.C       = b.C;
   assign s.cnt_clr = b.cnt_clr;
   assign s.tt_load = b.tt_load;
   assign s.tt_data = b.tt_data;
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic set_abc(input logic [2:0] v);
      {b.A, b.B, b.C} = v;
   endtask
   logic f_exp [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
   initial begin
      b.cnt_clr = 1'b0;
      b.tt_load = 1'b0;
      b.tt_data = 8'h00;
      set_abc(3'b010);
      #4;
      chk("comb_f_no_clock", 32'(b.F), 32'd1);
      chk("reset_f_q", 32'(b.f_q), 32'd0);
      chk("reset_f_rise", 32'(b.f_rise), 32'd0);
      chk("reset_hi_cnt", 32'(b.hi_cnt), 32'd0);
      for (int i = 0; i < 8; i++) begin
         set_abc(3'(i));
         #1;
         chk($sformatf("sweep_f_%0d", i), 32'(b.F), 32'(f_exp[i]));
      end
      set_abc(3'b000);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("f_q_low", 32'(b.f_q), 32'd0);
      chk("hi_cnt_f0", 32'(b.hi_cnt), 32'd0);
      set_abc(3'b010);
      tick();
      chk("e1_f_q", 32'(b.f_q), 32'd1);
      chk("e1_f_rise", 32'(b.f_rise), 32'd1);
      chk("e1_hi_cnt", 32'(b.hi_cnt), 32'd1);
      tick();
      chk("e2_f_rise", 32'(b.f_rise), 32'd0);
      chk("e2_hi_cnt", 32'(b.hi_cnt), 32'd2);
      tick();
      chk("e3_f_q", 32'(b.f_q), 32'd1);
      chk("e3_f_rise", 32'(b.f_rise), 32'd0);
      chk("e3_hi_cnt", 32'(b.hi_cnt), 32'd3);
      b.cnt_clr = 1'b1;
      tick();
      chk("clr_priority", 32'(b.hi_cnt), 32'd0);
      b.cnt_clr = 1'b0;
      repeat (5) tick();
      chk("pre_reset_hi_cnt", 32'(b.hi_cnt), 32'd5);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_f_q", 32'(b.f_q), 32'd0);
      chk("async_f_rise", 32'(b.f_rise), 32'd0);
      chk("async_hi_cnt", 32'(b.hi_cnt), 32'd0);
      set_abc(3'b101);
      #1;
      chk("reset_f_tracks", 32'(b.F), 32'd1);
      set_abc(3'b110);
      #1;
      chk("reset_f_tracks_0", 32'(b.F), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      b.cnt_clr = 1'b1;
      set_abc(3'b000);
      tick();
      chk("sat_clr_hi", 32'(s.hi_cnt), 32'd0);
      b.cnt_clr = 1'b0;
      set_abc(3'b010);
      repeat (15) tick();
      chk("sat_reach", 32'(s.hi_cnt), 32'hF);
      repeat (5) tick();
      chk("sat_hold", 32'(s.hi_cnt), 32'hF);
      chk("wide_count_20", 32'(b.hi_cnt), 32'd20);
      set_abc(3'b000);
      tick();
      chk("f_q_fall", 32'(b.f_q), 32'd0);
      chk("hi_cnt_hold_f0", 32'(b.hi_cnt), 32'd20);
      set_abc(3'b010);
      b.tt_load = 1'b1;
      b.tt_data = 8'h80;
      #1;
      chk("load_pre_edge_f", 32'(b.F), 32'd1);
      tick();
      b.tt_load = 1'b0;
      chk("load_edge_f_q_old", 32'(b.f_q), 32'd1);
`ifdef BOOLEAN_PROG_EN
      chk("load_post_010", 32'(b.F), 32'd0);
`else
      chk("load_ignored_010", 32'(b.F), 32'd1);
`endif
      set_abc(3'b111);
      #1;
      chk("load_post_111", 32'(b.F), 32'd1);
      set_abc(3'b100);
      #1;
      chk("load_post_100", 32'(b.F), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
